// File: rtl/lsu_pkg.sv
// Shared types for the load/store stage: access sizes, FSM states and the alignment rule.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EXT,
    ST_WR,
    ST_ERR
  } lsu_state_e;

  // Encoding 2'b11 has no access type of its own and behaves as a word.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 32-bit SRAM word and sub-word accesses:
// load extraction with sign/zero extension, and the store merge used by read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      off,
  input  size_e           size,
  input  logic            zext,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] merged
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] wrep;
  logic [3:0]      lane_en;

  always_comb begin
    byte_sh  = rdata >> {off, 3'b000};
    half_sh  = rdata >> {off[1], 4'b0000};
    load_val = rdata;
    lane_en  = 4'b1111;
    wrep     = wdata;
    case (size)
      SZ_B: begin
        load_val = {{(XLEN-8){~zext & byte_sh[7]}}, byte_sh[7:0]};
        lane_en  = 4'b0001 << off;
        wrep     = {4{wdata[7:0]}};
      end
      SZ_H: begin
        load_val = {{(XLEN-16){~zext & half_sh[15]}}, half_sh[15:0]};
        lane_en  = off[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Store data is replicated across lanes so each lane only chooses old vs new.
  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = lane_en[gi] ? wrep[gi*8 +: 8] : rdata[gi*8 +: 8];
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage onto a word-wide single-port SRAM; sub-word stores use read-modify-write.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests answer with resp_err instead of being force-aligned.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e        state_q;
  logic [ADDR_W+1:0] addr_q;
  size_e             size_q;
  logic              we_q;
  logic              zext_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   merge_q;

  size_e             req_sz;
  logic [ADDR_W+1:0] req_addr_al;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   merged;

  always_comb begin
    req_sz      = decode_size(req_size);
    req_addr_al = req_addr;
    case (req_sz)
      SZ_H:    req_addr_al[0]   = 1'b0;
      SZ_W:    req_addr_al[1:0] = 2'b00;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;
  assign req_mis = is_misaligned(req_sz, req_addr[1:0]);
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  // Gating with rst keeps a store caught in WR by reset from reaching the SRAM.
  assign mem_we    = (state_q == ST_WR) & ~rst;
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = (size_q == SZ_W) ? wdata_q : merge_q;

  lsu_lane_align u_align (
    .rdata    (mem_rdata),
    .wdata    (wdata_q),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .zext     (zext_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      merge_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr_al;
            size_q  <= req_sz;
            we_q    <= req_we;
            zext_q  <= req_unsigned;
            wdata_q <= req_wdata;
            if (req_we && req_sz == SZ_W) state_q <= ST_WR;
            else                          state_q <= ST_RD;
`ifdef LSU_MISALIGN_TRAP_EN
            if (req_mis) state_q <= ST_ERR;
`endif
          end
        end
        ST_RD: state_q <= ST_EXT;
        ST_EXT: begin
          if (we_q) begin
            merge_q <= merged;
            state_q <= ST_WR;
          end else begin
            resp_rdata <= load_val;
            resp_valid <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        ST_WR: begin
          resp_valid <= 1'b1;
          state_q    <= ST_IDLE;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        ST_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          state_q    <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed table, random traffic vs a byte-array model,
// back-to-back and reset-during-write sequences.
module tb_lsu_mem_stage;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  lsu_mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External SRAM: registered read, write on mem_we.
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  int                we_total = 0;
  logic [ADDR_W-1:0] we_addr_last = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_total     <= we_total + 1;
      we_addr_last <= mem_addr;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, little-endian.
  logic [7:0]  ref_b [0:(4<<ADDR_W)-1];
  logic [31:0] last_rd = '0;

  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input int addr,
                       input logic [31:0] wd, output logic [31:0] e_rd, output logic e_err,
                       output int e_lat, output int e_we, output int e_waddr);
    int nbytes;
    int a;
    logic [31:0] v;
    nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a       = addr;
    e_err   = 1'b0;
    e_rd    = last_rd;
    e_we    = 0;
    e_waddr = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % nbytes) != 0) begin
      e_err = 1'b1;
      e_lat = 2;
      return;
    end
`endif
    a       = a - (a % nbytes);
    e_waddr = a / 4;
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_b[a+i] = wd[8*i +: 8];
      e_we  = 1;
      e_lat = (nbytes == 4) ? 2 : 4;
    end else begin
      v = '0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_b[a+i];
      if (!uns && nbytes < 4 && v[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) v[8*i +: 8] = 8'hFF;
      e_rd    = v;
      last_rd = v;
      e_lat   = 3;
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input int addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int lat, output int nwe);
    int guard;
    int we0;
    @(negedge clk);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = (ADDR_W+2)'(addr);
    req_wdata    = wd;
    req_valid    = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    we0 = we_total;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 12);
    rd  = resp_rdata;
    err = resp_err;
    nwe = we_total - we0;
  endtask

  task automatic check_txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                           input int addr, input logic [31:0] wd, input logic [31:0] e_rd,
                           input logic e_err, input int e_lat, input int e_we, input int e_waddr);
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nwe;
    xact(we, sz, uns, addr, wd, rd, err, lat, nwe);
    $display("txn %s we=%0d sz=%0d u=%0d addr=0x%03h wd=0x%08h -> rd=0x%08h err=%0d lat=%0d nwe=%0d",
             tag, we, sz, uns, addr, wd, rd, err, lat, nwe);
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_nwe"}, 32'(nwe), 32'(e_we));
    if (e_we != 0) chk({tag, "_waddr"}, 32'(we_addr_last), 32'(e_waddr));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    int          addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        chk_rd;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat, m_we, m_wa;
    logic [31:0] bb_exp [3];
    int          bb_addr [3];
    int          acc_cyc [3];
    int          resp_cyc [3];
    int          k, got, c, pulses;
    logic        acc;

    // Directed vectors from the documented scenarios.
    vecs.push_back('{1'b1, 2'd2, 1'b0, 'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 'h010, 32'h0,        32'hDEADBEEF, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 'h010, 32'h11223344, 32'h0,        1'b0, 2, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 'h012, 32'h000000AA, 32'h0,        1'b0, 4, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 'h010, 32'h0,        32'h11AA3344, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 'h020, 32'h80FF7F01, 32'h0,        1'b0, 2, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 'h023, 32'h0,        32'hFFFFFF80, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 'h023, 32'h0,        32'h00000080, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 'h022, 32'h0,        32'hFFFF80FF, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 'h020, 32'h0,        32'h00007F01, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 'h020, 32'h0,        32'h80FF7F01, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 'h3FC, 32'hA5123456, 32'h0,        1'b0, 2, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 'h3FF, 32'h0,        32'hFFFFFFA5, 1'b1, 3, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 'h3FF, 32'h0,        32'h000000A5, 1'b1, 3, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{1'b0, 2'd2, 1'b0, 'h021, 32'h0,        32'h0,        1'b0, 2, 1'b1});
`else
    vecs.push_back('{1'b0, 2'd2, 1'b0, 'h021, 32'h0,        32'h80FF7F01, 1'b1, 3, 1'b0});
`endif

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);

    // Prefill the random-traffic region so every load reads a known word.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      model(1'b1, 2'd2, 1'b0, i*4, d, m_rd, m_err, m_lat, m_we, m_wa);
      check_txn("fill", 1'b1, 2'd2, 1'b0, i*4, d, m_rd, m_err, m_lat, m_we, m_wa);
    end

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, m_rd, m_err, m_lat, m_we, m_wa);
      if (vecs[i].chk_rd) m_rd = vecs[i].rd;
      check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                m_rd, vecs[i].err, vecs[i].lat, m_we, m_wa);
    end

    for (int i = 0; i < 60; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      int          addr;
      logic [31:0] wd;
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 63));
      wd   = $urandom;
      model(we, sz, uns, addr, wd, m_rd, m_err, m_lat, m_we, m_wa);
      check_txn("rand", we, sz, uns, addr, wd, m_rd, m_err, m_lat, m_we, m_wa);
    end

    // Three loads with req_valid held high: each accepted in its predecessor's response cycle.
    bb_addr[0] = 'h010;
    bb_addr[1] = 'h020;
    bb_addr[2] = 'h3FC;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i]  = -100;
      resp_cyc[i] = -50;
      model(1'b0, 2'd2, 1'b0, bb_addr[i], 32'h0, bb_exp[i], m_err, m_lat, m_we, m_wa);
    end
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = (ADDR_W+2)'(bb_addr[0]);
    req_valid = 1'b1;
    k = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (resp_valid) begin
        resp_cyc[got] = cyc;
        chk("b2b_rdata", resp_rdata, bb_exp[got]);
        got++;
      end
      acc = req_valid && req_ready;
      if (acc && k < 3) begin
        acc_cyc[k] = cyc;
        k++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (k < 3) req_addr = (ADDR_W+2)'(bb_addr[k]);
        else       req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    $display("txn b2b accepts=%0d/%0d/%0d responses=%0d/%0d/%0d",
             acc_cyc[0], acc_cyc[1], acc_cyc[2], resp_cyc[0], resp_cyc[1], resp_cyc[2]);
    chk("b2b_responses", 32'(got), 32'd3);
    chk("b2b_accepts", 32'(k), 32'd3);
    for (int i = 0; i < 3; i++) chk("b2b_lat", 32'(resp_cyc[i] - acc_cyc[i]), 32'd3);
    for (int i = 1; i < 3; i++) chk("b2b_overlap", 32'(acc_cyc[i]), 32'(resp_cyc[i-1]));

    // Reset while a sub-word store sits in WR: the write and its response are dropped.
    model(1'b1, 2'd2, 1'b0, 'h030, 32'h12345678, m_rd, m_err, m_lat, m_we, m_wa);
    check_txn("pre_rst", 1'b1, 2'd2, 1'b0, 'h030, 32'h12345678, m_rd, m_err, m_lat, m_we, m_wa);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = (ADDR_W+2)'('h031);
    req_wdata = 32'h000000EE;
    req_valid = 1'b1;
    chk("rst_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!mem_we && c < 10);
    chk("rst_wr_cycle", 32'(c), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_mem_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_word", sram[12], 32'h12345678);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    $display("txn rst_during_wr wr_cycle=%0d word12=0x%08h stray_resp=%0d", c, sram[12], pulses);
    chk("rst_no_response", 32'(pulses), 32'd0);
    last_rd = '0;
    model(1'b0, 2'd2, 1'b0, 'h030, 32'h0, m_rd, m_err, m_lat, m_we, m_wa);
    check_txn("post_rst", 1'b0, 2'd2, 1'b0, 'h030, 32'h0, m_rd, m_err, m_lat, m_we, m_wa);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
